// File: rtl/fetch_queue_stage_if.sv
// Bundle for the fetch stage: redirect input, instruction-memory request and
// response channels, and the decode-side delivery channel.
// The master modport is the fetch stage itself; slave is its environment.
//
// Handshake rule for both valid/ready channels: a transfer happens on a rising
// edge where valid && ready. Once valid rises, the payload holds steady until
// that transfer, unless a redirect withdraws it. The response channel has no
// ready signal: each response is consumed in the cycle it is presented.
interface fetch_queue_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int OccW = $clog2(DEPTH + 1);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_instr;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_pc_plus4;
  logic [OccW-1:0] occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, d_ready,
    output imem_req_valid, imem_req_addr, d_valid, d_instr, d_pc, d_pc_plus4,
           occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, d_ready,
    input  imem_req_valid, imem_req_addr, d_valid, d_instr, d_pc, d_pc_plus4,
           occupancy
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage with a decoupled fetch queue.
// Owns the PC, issues in-order requests to a variable-latency instruction
// memory, and holds up to DEPTH allocated entries (requested or fetched) that
// are handed to decode in program order. A redirect flushes the queue; memory
// responses still in flight at that moment are counted as stale and dropped.
// Optional macro FETCH_QUEUE_BYPASS_EN: a response for the head entry of a
// queue holding no fetched instruction is presented to decode in the same cycle.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic                 clk,
  input logic                 rst,
  fetch_queue_stage_if.master bus
);
  localparam int              PtrW = $clog2(DEPTH);
  localparam int              OccW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] Step = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pcArr    [DEPTH];
  logic [XLEN-1:0] instrArr [DEPTH];
  logic [DEPTH-1:0] filledArr;
  logic [PtrW-1:0] allocPtr, fillPtr, headPtr;
  logic [OccW-1:0] occ;    // allocated entries
  logic [OccW-1:0] pend;   // allocated entries still waiting for their response
  logic [OccW-1:0] stale;  // in-flight responses that belong to flushed entries

  logic [OccW:0] credit;
  logic reqValid, reqFire;
  logic rspStale, rspFill, rspCounted;
  logic headFilled, bypassHit, bypassPop;
  logic dValid, dFire;

  // Request credit counts both live entries and responses still owed to flushed ones.
  assign credit     = {1'b0, occ} + {1'b0, stale};
  assign reqValid   = rst && !bus.redirect_valid && (credit < (OccW + 1)'(DEPTH));
  assign reqFire    = reqValid && bus.imem_req_ready;

  assign rspStale   = bus.imem_rsp_valid && (stale != '0);
  assign rspFill    = bus.imem_rsp_valid && (stale == '0) && (pend != '0);
  // A response with nothing outstanding at all is ignored.
  assign rspCounted = bus.imem_rsp_valid && ((stale != '0) || (pend != '0));

  assign headFilled = (occ != '0) && filledArr[headPtr];
`ifdef FETCH_QUEUE_BYPASS_EN
  // occ == pend means no entry is fetched yet, so the fill slot is the head slot.
  assign bypassHit  = rspFill && (occ == pend);
`else
  assign bypassHit  = 1'b0;
`endif
  assign dValid     = rst && !bus.redirect_valid && (headFilled || bypassHit);
  assign dFire      = dValid && bus.d_ready;
  assign bypassPop  = bypassHit && dFire;

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = pc;
  assign bus.d_valid        = dValid;
  assign bus.d_instr        = !dValid ? '0 : (bypassHit ? bus.imem_rsp_data : instrArr[headPtr]);
  assign bus.d_pc           = dValid ? pcArr[headPtr] : '0;
  assign bus.d_pc_plus4     = dValid ? pcArr[headPtr] + Step : '0;
  assign bus.occupancy      = occ;

  // PC, queue storage, pointers and counters; redirect overrides all other activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      filledArr <= '0;
      allocPtr  <= '0;
      fillPtr   <= '0;
      headPtr   <= '0;
      occ       <= '0;
      pend      <= '0;
      stale     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcArr[i]    <= '0;
        instrArr[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      pc        <= bus.redirect_pc;
      filledArr <= '0;
      allocPtr  <= '0;
      fillPtr   <= '0;
      headPtr   <= '0;
      occ       <= '0;
      pend      <= '0;
      // Every unfilled entry still owes a response; a same-cycle response pays one off.
      stale     <= stale + pend - OccW'(rspCounted);
    end else begin
      if (rspStale) begin
        stale <= stale - OccW'(1);
      end
      if (rspFill) begin
        if (!bypassPop) begin
          instrArr[fillPtr]  <= bus.imem_rsp_data;
          filledArr[fillPtr] <= 1'b1;
        end
        fillPtr <= fillPtr + PtrW'(1);
      end
      // The alloc slot is always free here, so it never collides with the fill slot.
      if (reqFire) begin
        pcArr[allocPtr]     <= pc;
        filledArr[allocPtr] <= 1'b0;
        allocPtr            <= allocPtr + PtrW'(1);
        pc                  <= pc + Step;
      end
      if (dFire) begin
        headPtr <= headPtr + PtrW'(1);
      end
      occ  <= occ + OccW'(reqFire) - OccW'(dFire);
      pend <= pend + OccW'(reqFire) - OccW'(rspFill);
    end
  end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Testbench for fetch_queue_stage: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a queue-based
// model of the fetch queue and an in-order memory model.
module tb_fetch_queue_stage;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] STEP     = 32'd4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;

  ent_t        mq[$];      // allocated entries, oldest first
  logic [31:0] mpc;        // model PC
  int          stale;      // responses owed to flushed entries
  logic [31:0] memQ[$];    // addresses accepted by memory, awaiting response
  logic [31:0] reqLog[$];  // accepted request addresses
  logic [31:0] popPc[$];   // d_pc at each decode transfer
  logic [31:0] popPc4[$];  // d_pc_plus4 at each decode transfer
  int          rspPct  = 100;
  int          spurPct = 0;
  int          nCmp    = 0;
  int          nBad    = 0;
  bit          expReqV, expDV;
  logic        lastDValid;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void checkOutputs();
    logic [31:0] expI, expP, expP4;
    expReqV = ((mq.size() + stale) < DEPTH) && !bus.redirect_valid;
    expDV = 1'b0;
    expI  = '0;
    expP  = '0;
    expP4 = '0;
    if (!bus.redirect_valid && mq.size() > 0) begin
      if (mq[0].filled) begin
        expDV = 1'b1;
        expI  = mq[0].instr;
        expP  = mq[0].pc;
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      else if (bus.imem_rsp_valid && stale == 0) begin
        expDV = 1'b1;
        expI  = bus.imem_rsp_data;
        expP  = mq[0].pc;
      end
`endif
    end
    if (expDV) expP4 = expP + STEP;
    cmp("req_valid", 32'(bus.imem_req_valid), 32'(expReqV));
    cmp("req_addr", bus.imem_req_addr, mpc);
    cmp("d_valid", 32'(bus.d_valid), 32'(expDV));
    cmp("d_instr", bus.d_instr, expI);
    cmp("d_pc", bus.d_pc, expP);
    cmp("d_pc_plus4", bus.d_pc_plus4, expP4);
    cmp("occupancy", 32'(bus.occupancy), 32'(mq.size()));
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs, check outputs, then advance memory and model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit reqRdy, input bit dRdy);
    bit          rsp, reqF, dF, done;
    logic [31:0] rdata;
    int          unf;
    ent_t        e;
    @(negedge clk);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = reqRdy;
    bus.d_ready        = dRdy;
    rsp   = 1'b0;
    rdata = $urandom;
    if (memQ.size() > 0) begin
      if ($urandom_range(0, 99) < rspPct) begin
        rsp   = 1'b1;
        rdata = instrOf(memQ[0]);
      end
    end else if ($urandom_range(0, 99) < spurPct) begin
      rsp = 1'b1;
    end
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rdata;
    #1;
    checkOutputs();
    lastDValid = bus.d_valid;
    reqF = bus.imem_req_valid && reqRdy;
    dF   = bus.d_valid && dRdy;
    if (reqF) reqLog.push_back(bus.imem_req_addr);
    if (dF) begin
      popPc.push_back(bus.d_pc);
      popPc4.push_back(bus.d_pc_plus4);
    end
    @(posedge clk);
    if (rsp && memQ.size() > 0) void'(memQ.pop_front());
    if (reqF) memQ.push_back(bus.imem_req_addr);
    if (redir) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      if (rsp && (stale + unf) > 0) stale = stale + unf - 1;
      else stale = stale + unf;
      mq.delete();
      mpc = rpc;
    end else begin
      if (rsp) begin
        if (stale > 0) begin
          stale--;
        end else begin
          done = 1'b0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!done && !mq[i].filled) begin
              e        = mq[i];
              e.filled = 1'b1;
              e.instr  = rdata;
              mq[i]    = e;
              done     = 1'b1;
            end
          end
        end
      end
      if (expDV && dRdy) void'(mq.pop_front());
      if (expReqV && reqRdy) begin
        e.pc     = mpc;
        e.instr  = '0;
        e.filled = 1'b0;
        mq.push_back(e);
        mpc = mpc + STEP;
      end
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.d_ready        = 1'b0;
    #1;
    cmp("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    cmp("rst_d_valid", 32'(bus.d_valid), 32'h0);
    cmp("rst_occupancy", 32'(bus.occupancy), 32'h0);
    cmp("rst_d_instr", bus.d_instr, 32'h0);
    cmp("rst_d_pc", bus.d_pc, 32'h0);
    cmp("rst_d_pc_plus4", bus.d_pc_plus4, 32'h0);
    mq.delete();
    memQ.delete();
    stale = 0;
    mpc   = RESET_PC;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clearLogs();
    reqLog.delete();
    popPc.delete();
    popPc4.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rIdx, pIdx, base;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.d_ready        = 1'b0;
    mpc   = RESET_PC;
    stale = 0;

    doReset();

    // Decode stalled: queue fills with exactly DEPTH requests.
    rspPct = 100;
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    #1;
    cmp("fill_occupancy", 32'(bus.occupancy), 32'd4);
    cmp("fill_req_valid", 32'(bus.imem_req_valid), 32'h0);
    cmp("fill_req_count", 32'(reqLog.size()), 32'd4);
    cmp("fill_req0", reqLog[0], 32'h0);
    cmp("fill_req3", reqLog[3], 32'hC);

    // Pop one to reach occupancy 3, then reset mid-operation.
    step(1'b0, '0, 1'b0, 1'b1);
    #1;
    cmp("pop_occupancy", 32'(bus.occupancy), 32'd3);
    cmp("pop_pc0", popPc[0], 32'h0);
    cmp("pop_pc4_0", popPc4[0], 32'h4);
    doReset();
    clearLogs();

    // Streaming with memory and decode always ready.
    step(1'b0, '0, 1'b1, 1'b1);
    cmp("first_req_after_reset", reqLog[0], RESET_PC);
    step(1'b0, '0, 1'b1, 1'b1);
    cmp("rsp_cycle_d_valid", 32'(lastDValid), BYP);
    step(1'b0, '0, 1'b1, 1'b1);
    cmp("next_cycle_d_valid", 32'(lastDValid), 32'd1);
    repeat (5) step(1'b0, '0, 1'b1, 1'b1);
    base = popPc.size();
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    cmp("throughput_8_cycles", 32'(popPc.size() - base), 32'd8);
    cmp("stream_pc0", popPc[0], 32'h0);
    cmp("stream_pc1", popPc[1], 32'h4);
    cmp("stream_pc4_1", popPc4[1], 32'h8);

    // Redirect with responses for 0x8 and 0xC outstanding, one arriving that cycle.
    doReset();
    clearLogs();
    rspPct = 0;
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);
    rspPct = 100;
    repeat (2) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    cmp("redir_d_valid", 32'(lastDValid), 32'h0);
    rIdx = reqLog.size();
    pIdx = popPc.size();
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    cmp("redir_first_req", reqLog[rIdx], 32'h100);
    cmp("redir_first_pop", popPc[pIdx], 32'h100);
    cmp("redir_first_pop4", popPc4[pIdx], 32'h104);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    rIdx = reqLog.size();
    pIdx = popPc.size();
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    cmp("wrap_req0", reqLog[rIdx], 32'hFFFF_FFFC);
    cmp("wrap_req1", reqLog[rIdx + 1], 32'h0);
    cmp("wrap_pop", popPc[pIdx], 32'hFFFF_FFFC);
    cmp("wrap_pop4", popPc4[pIdx], 32'h0);

    // Randomized traffic in chunks separated by resets.
    spurPct = 5;
    for (int c = 0; c < 5; c++) begin
      doReset();
      clearLogs();
      rspPct = $urandom_range(30, 100);
      for (int k = 0; k < 300; k++) begin
        step($urandom_range(0, 99) < 4, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
